// File: rtl/handshake_arb.sv
// Round-robin arbiter of N req/grt sources onto one registered req/grt drain,
// with source-channel tag and transfer counters. Optional stall: HANDSHAKE_ARB_STALL_EN.
module handshake_arb #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 32,
  parameter int LW = 8,
  parameter logic [LW-1:0] LP = 8'b10111000,
  parameter logic [LW-1:0] LR = 8'b00000001,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_req,
  input  logic [N*DW-1:0] in_dat,
  output logic [N-1:0]    in_grt,
  output logic            out_req,
  output logic [DW-1:0]   out_dat,
  output logic [IW-1:0]   out_chn,
  input  logic            out_grt,
  output logic [N*CW-1:0] cnt_chn,
  output logic [CW-1:0]   cnt_tot
);

  // Handshake: a word moves on a rising edge where req and grt are both high,
  // upstream (in_req[i] & in_grt[i]) and downstream (out_req & out_grt) alike.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic          any_req;
  logic [IW-1:0] win;
  logic [DW-1:0] sel_dat;
  logic          dn_xfer;
  logic          free;
  logic          accept;

  // First requesting channel at or after the pointer, searching cyclically.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    sel_dat = '0;
    for (int o = 0; o < N; o++) begin
      if (!any_req && in_req[(int'(ptr) + o) % N]) begin
        any_req = 1'b1;
        win     = IW'((int'(ptr) + o) % N);
        sel_dat = in_dat[((int'(ptr) + o) % N) * DW +: DW];
      end
    end
  end

`ifdef HANDSHAKE_ARB_STALL_EN
  logic [LW-1:0] rnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd <= LR;
    end else begin
      rnd <= {rnd[0], rnd[LW-1:1]} ^ ({LW{rnd[0]}} & LP);
    end
  end

  // A stall cycle (rnd[0] low) hides the held word from the drain.
  assign out_req = (state == FULL) & rnd[0];
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (^{LP, LR}) ^ (LW > 0);
  assign out_req = (state == FULL);
`endif

  assign dn_xfer = out_req & out_grt;
  assign free    = (state == EMPTY) | dn_xfer;
  assign accept  = rst & free & any_req;
  assign in_grt  = accept ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      ptr     <= '0;
      out_dat <= '0;
      out_chn <= '0;
      cnt_chn <= '0;
      cnt_tot <= '0;
    end else begin
      if (accept) begin
        state   <= FULL;
        out_dat <= sel_dat;
        out_chn <= win;
        ptr     <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
      end else if (dn_xfer) begin
        state <= EMPTY;
      end
      if (dn_xfer) begin
        cnt_tot <= cnt_tot + 1'b1;
      end
      // Per-channel counts saturate rather than wrap.
      for (int k = 0; k < N; k++) begin
        if (accept && (win == IW'(k)) && (cnt_chn[k*CW +: CW] != {CW{1'b1}})) begin
          cnt_chn[k*CW +: CW] <= cnt_chn[k*CW +: CW] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_handshake_arb.sv
// Directed bench for handshake_arb (N=4, DW=8, CW=4): vector table plus
// hand-written reset, async-reset and saturation sequences.
module tb_handshake_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  localparam logic [31:0] D0 = 32'hA3A2A1A0;
  localparam logic [31:0] D1 = 32'hA35CA1A0;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_req;
  logic [N*DW-1:0] in_dat;
  logic [N-1:0]    in_grt;
  logic            out_req;
  logic [DW-1:0]   out_dat;
  logic [IW-1:0]   out_chn;
  logic            out_grt;
  logic [N*CW-1:0] cnt_chn;
  logic [CW-1:0]   cnt_tot;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0]  req;
    logic        og;
    logic [31:0] dat;
    logic [3:0]  grt;
    logic        oreq;
    logic [7:0]  odat;
    logic [1:0]  ochn;
    logic [3:0]  tot;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  logic [IW+DW-1:0] exp_q[$];
  logic sb_on = 1'b0;

  handshake_arb #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_req  (in_req),
    .in_dat  (in_dat),
    .in_grt  (in_grt),
    .out_req (out_req),
    .out_dat (out_dat),
    .out_chn (out_chn),
    .out_grt (out_grt),
    .cnt_chn (cnt_chn),
    .cnt_tot (cnt_tot)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic og, input logic [31:0] dat,
                     input logic [3:0] grt, input logic oreq, input logic [7:0] odat,
                     input logic [1:0] ochn, input logic [3:0] tot, input logic [15:0] cnt);
    vq.push_back('{req, og, dat, grt, oreq, odat, ochn, tot, cnt});
  endtask

  // Scoreboard: every downstream transfer must match the front of exp_q.
  always @(negedge clk) begin
    #2;
    if (sb_on && rst && out_req && out_grt) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {22'd0, out_chn, out_dat}, 32'hFFFF_FFFF);
      end else begin
        check("sb_word", {22'd0, out_chn, out_dat}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst    = 1'b0;
    in_req = 4'hF;
    in_dat = D0;
    out_grt = 1'b1;

    // Reset held: no grants, empty stage, zero counters.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_grt%0d", i), {28'd0, in_grt}, 32'd0);
      check($sformatf("rst_oreq%0d", i), {31'd0, out_req}, 32'd0);
      check($sformatf("rst_cnt%0d", i), {16'd0, cnt_chn}, 32'd0);
      check($sformatf("rst_tot%0d", i), {28'd0, cnt_tot}, 32'd0);
      check($sformatf("rst_dat%0d", i), {22'd0, out_chn, out_dat}, 32'd0);
    end

    // Values are the ones visible in the cycle before each edge.
    // Round-robin streaming, all channels requesting.
    add(4'hF, 1, D0, 4'h1, 0, 8'h00, 0, 4'h0, 16'h0000);
    add(4'hF, 1, D0, 4'h2, 1, 8'hA0, 0, 4'h0, 16'h0001);
    add(4'hF, 1, D0, 4'h4, 1, 8'hA1, 1, 4'h1, 16'h0011);
    add(4'hF, 1, D0, 4'h8, 1, 8'hA2, 2, 4'h2, 16'h0111);
    add(4'hF, 1, D0, 4'h1, 1, 8'hA3, 3, 4'h3, 16'h1111);
    add(4'hF, 1, D0, 4'h2, 1, 8'hA0, 0, 4'h4, 16'h1112);
    add(4'hF, 1, D0, 4'h4, 1, 8'hA1, 1, 4'h5, 16'h1122);
    add(4'hF, 1, D0, 4'h8, 1, 8'hA2, 2, 4'h6, 16'h1222);
    add(4'h0, 1, D0, 4'h0, 1, 8'hA3, 3, 4'h7, 16'h2222);
    // Backpressure: one accept from ch2, then hold while source data changes.
    add(4'h4, 0, D0, 4'h4, 0, 8'hA3, 3, 4'h8, 16'h2222);
    for (int i = 0; i < 5; i++) add(4'h4, 0, D1, 4'h0, 1, 8'hA2, 2, 4'h8, 16'h2322);
    add(4'h4, 1, D1, 4'h4, 1, 8'hA2, 2, 4'h8, 16'h2322);
    add(4'h0, 1, D1, 4'h0, 1, 8'h5C, 2, 4'h9, 16'h2422);
    // Pointer skip and wrap: ptr 3 -> ch0, then ptr 1 with req 1001 -> ch3, ch0.
    add(4'h1, 1, D0, 4'h1, 0, 8'h5C, 2, 4'hA, 16'h2422);
    add(4'h9, 1, D0, 4'h8, 1, 8'hA0, 0, 4'hA, 16'h2423);
    add(4'h9, 1, D0, 4'h1, 1, 8'hA3, 3, 4'hB, 16'h3423);
    add(4'h0, 1, D0, 4'h0, 1, 8'hA0, 0, 4'hC, 16'h3424);

    @(negedge clk);
    rst = 1'b1;
    foreach (vq[i]) begin
      if (i > 0) @(negedge clk);
      in_req  = vq[i].req;
      out_grt = vq[i].og;
      in_dat  = vq[i].dat;
      #1;
      check($sformatf("v%0d_in_grt", i), {28'd0, in_grt}, {28'd0, vq[i].grt});
      check($sformatf("v%0d_out_req", i), {31'd0, out_req}, {31'd0, vq[i].oreq});
      check($sformatf("v%0d_out_dat", i), {24'd0, out_dat}, {24'd0, vq[i].odat});
      check($sformatf("v%0d_out_chn", i), {30'd0, out_chn}, {30'd0, vq[i].ochn});
      check($sformatf("v%0d_cnt_tot", i), {28'd0, cnt_tot}, {28'd0, vq[i].tot});
      check($sformatf("v%0d_cnt_chn", i), {16'd0, cnt_chn}, {16'd0, vq[i].cnt});
    end
    @(negedge clk);
    #1;
    check("post_table_out_req", {31'd0, out_req}, 32'd0);
    check("post_table_cnt_tot", {28'd0, cnt_tot}, 32'hD);

    // Async reset while FULL with the drain blocked.
    in_req  = 4'h1;
    out_grt = 1'b0;
    @(negedge clk);
    in_req = 4'hF;
    @(posedge clk);
    #2;
    check("arst_pre_out_req", {31'd0, out_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_out_req", {31'd0, out_req}, 32'd0);
    check("arst_in_grt", {28'd0, in_grt}, 32'd0);
    check("arst_cnt_chn", {16'd0, cnt_chn}, 32'd0);
    check("arst_cnt_tot", {28'd0, cnt_tot}, 32'd0);
    check("arst_out_dat", {22'd0, out_chn, out_dat}, 32'd0);
    @(negedge clk);
    in_req  = 4'h0;
    out_grt = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("arst_after_oreq%0d", i), {31'd0, out_req}, 32'd0);
      check($sformatf("arst_after_tot%0d", i), {28'd0, cnt_tot}, 32'd0);
    end

    // Saturation/wrap: 20 accepts from ch0 at full rate.
    sb_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back({2'd0, 8'hA0});
      @(negedge clk);
      in_req = 4'h1;
    end
    @(negedge clk);
    in_req = 4'h0;
    @(negedge clk);
    #3;
    sb_on = 1'b0;
    check("sat_cnt_chn", {16'd0, cnt_chn}, 32'h000F);
    check("wrap_cnt_tot", {28'd0, cnt_tot}, 32'h4);
    check("sat_out_req", {31'd0, out_req}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
